sysbus_line_fetcher: RTL

Parametrised Sysbus read-line engine. It replaces the ad-hoc fetch state machine inside the core top level. It accepts a line-read request from the fetch stage and issues one Sysbus READ/MEMORY transaction. It then collects BEATS response beats into one line buffer and hands the completed line back over a valid/ready port. Supports flush/redirect mid-transaction by draining orphaned beats, plus a configurable transaction ID in the tag.

---
 rtl/sysbus_pkg.sv | 28 ++
 rtl/beat_assembler.sv | 41 ++++
 rtl/sysbus_line_fetcher.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions for the line fetcher: fetch states, tag layout
// and the transaction-type codes carried in the request tag.
package sysbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN,
    DONE
  } fetch_state_t;

  // Tag layout is {rw, target, id}; only the id field is matched on responses.
  localparam int TAG_ID_WIDTH     = 8;
  localparam int TAG_TARGET_WIDTH = 4;

  localparam logic                        SYSBUS_READ   = 1'b1;
  localparam logic [TAG_TARGET_WIDTH-1:0] SYSBUS_MEMORY = 4'b0001;

  function automatic logic [TAG_ID_WIDTH+TAG_TARGET_WIDTH:0] make_tag(
    input logic                        rw,
    input logic [TAG_TARGET_WIDTH-1:0] target,
    input logic [TAG_ID_WIDTH-1:0]     id
  );
    return {rw, target, id};
  endfunction

endpackage

// File: rtl/beat_assembler.sv
// Beat counter plus line buffer: each stored beat lands in the slot selected
// by the current count, so beat k ends up at bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
module beat_assembler #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BEATS          = 8,
  parameter int LINE_BITS      = BUS_DATA_WIDTH * BEATS,
  parameter int COUNT_WIDTH    = $clog2(BEATS) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      take,
  input  logic                      store,
  input  logic [BUS_DATA_WIDTH-1:0] beat,
  output logic [COUNT_WIDTH-1:0]    count,
  output logic [LINE_BITS-1:0]      line
);

  // Counting and storing are separate so that drained beats advance the count
  // without overwriting the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      line  <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (take) begin
        count <= count + COUNT_WIDTH'(1);
      end
      if (store) begin
        for (int k = 0; k < BEATS; k++) begin
          if (count == COUNT_WIDTH'(k)) begin
            line[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= beat;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sysbus_line_fetcher.sv
// Sysbus read-line engine: issues one READ/MEMORY request per accepted line
// address, assembles BEATS response beats and returns the line on a valid/ready port.
module sysbus_line_fetcher
  import sysbus_pkg::*;
#(
  parameter int          BUS_DATA_WIDTH = 64,
  parameter int          BUS_TAG_WIDTH  = 13,
  parameter int          BEATS          = 8,
  parameter logic [7:0]  TAG_ID         = 8'h00,
  parameter int          LINE_BITS      = BUS_DATA_WIDTH * BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_addr,
  input  logic                      flush,
  output logic                      line_valid,
  input  logic                      line_ready,
  output logic [LINE_BITS-1:0]      line_data,
  output logic [63:0]               line_addr,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int COUNT_WIDTH = $clog2(BEATS) + 1;
  localparam int OFFSET_BITS = $clog2(BEATS * BUS_DATA_WIDTH / 8);
  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << OFFSET_BITS) - 64'd1);
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG =
    BUS_TAG_WIDTH'(make_tag(SYSBUS_READ, SYSBUS_MEMORY, TAG_ID));

  fetch_state_t state, next_state;
  logic [COUNT_WIDTH-1:0] count;
  logic flushed;
  logic taken;
  logic last;
  logic accept;
  logic asm_clear, asm_take, asm_store;
  logic unused_resptag;

  assign taken  = bus_respcyc && (bus_resptag[TAG_ID_WIDTH-1:0] == TAG_ID);
  assign last   = (count == COUNT_WIDTH'(BEATS - 1));
  assign accept = (state == IDLE) && req_valid && !flush;
  assign unused_resptag = ^bus_resptag[BUS_TAG_WIDTH-1:TAG_ID_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A flush seen while the request is still un-acked must survive until the
  // ack, because the bus will still return a full set of beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_addr <= '0;
      flushed   <= 1'b0;
    end else if (accept) begin
      line_addr <= req_addr & ALIGN_MASK;
      flushed   <= 1'b0;
    end else if (state == REQ && flush) begin
      flushed   <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = REQ;
      REQ:   if (bus_reqack) next_state = (flushed || flush) ? DRAIN : RESP;
      RESP: begin
        if (taken && last)  next_state = flush ? IDLE : DONE;
        else if (flush)     next_state = DRAIN;
      end
      DRAIN: if (taken && last) next_state = IDLE;
      DONE:  if (flush || line_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    line_valid  = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    asm_clear   = 1'b0;
    asm_take    = 1'b0;
    asm_store   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        asm_clear = 1'b1;
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'(line_addr);
        bus_reqtag = REQ_TAG;
      end
      RESP: begin
        bus_respack = taken;
        asm_take    = taken;
        asm_store   = taken && !flush;
      end
      DRAIN: begin
        bus_respack = taken;
        asm_take    = taken;
      end
      DONE: line_valid = 1'b1;
      default: ;
    endcase
  end

  beat_assembler #(
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
    .BEATS          (BEATS),
    .LINE_BITS      (LINE_BITS),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_assembler (
    .clk   (clk),
    .reset (reset),
    .clear (asm_clear),
    .take  (asm_take),
    .store (asm_store),
    .beat  (bus_resp),
    .count (count),
    .line  (line_data)
  );

endmodule
